idma_legalizer_r_obi_w_axi_burst: RTL and testbench

// - Splits one generic 1D copy (src, dst, length) into OBI word reads and AXI write bursts.
// - Read side: one OBI request per data word. Write side: INCR bursts capped by page, MaxBeats and a runtime cap.
// - Read and write sides always advance independently. Sits between the iDMA frontend/midend and the OBI-read/AXI-write backend.
// - Successor to the fixed OBI/AXI legalizer: adds a parametrised burst cap, a runtime length cap, a done pulse and an optional zero-length path.

---
 rtl/idma_legalizer_r_obi_w_axi_burst.sv | 189 ++++++++++++++++++
 tb/tb_idma_legalizer_r_obi_w_axi_burst.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/idma_legalizer_r_obi_w_axi_burst.sv
`default_nettype none
// ============================================================================
// Module      : idma_legalizer_r_obi_w_axi_burst
// Description : Splits a 1D copy (src, dst, len) into one OBI read request per
//               data word and AXI INCR write bursts capped by the page size,
//               MAX_BEATS and a runtime 2**max_llen beat limit. The read and
//               write sides advance independently.
//               Optional feature macro: IDMA_LEGALIZER_ZERO_LEN_EN (accept
//               zero-length requests and only pulse done).
// Revision    : 1.0 - initial release
// ============================================================================
module idma_legalizer_r_obi_w_axi_burst #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 32,
    parameter int MAX_BEATS  = 256,
    parameter int PAGE_SIZE  = 4096,
    localparam int c_STRB_WIDTH = DATA_WIDTH / 8,
    localparam int c_OFF_WIDTH  = $clog2(c_STRB_WIDTH)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [LEN_WIDTH-1:0]   req_len_i,
    input  logic [ADDR_WIDTH-1:0]  req_src_addr_i,
    input  logic [ADDR_WIDTH-1:0]  req_dst_addr_i,
    input  logic [2:0]             req_max_llen_i,
    output logic                   r_valid_o,
    input  logic                   r_ready_i,
    output logic [ADDR_WIDTH-1:0]  r_addr_o,
    output logic [c_OFF_WIDTH-1:0] r_offset_o,
    output logic [c_OFF_WIDTH:0]   r_num_bytes_o,
    output logic                   w_valid_o,
    input  logic                   w_ready_i,
    output logic [ADDR_WIDTH-1:0]  w_addr_o,
    output logic [7:0]             w_len_o,
    output logic [c_OFF_WIDTH-1:0] w_offset_o,
    output logic [c_OFF_WIDTH-1:0] w_tailer_o,
    output logic                   w_last_o,
    input  logic                   flush_i,
    input  logic                   kill_i,
    output logic                   done_o,
    output logic                   r_busy_o,
    output logic                   w_busy_o
);

    // One bit wider than the length so chunk arithmetic never overflows
    typedef logic [LEN_WIDTH:0]   len_ext_t;
    typedef logic [c_OFF_WIDTH:0] nbytes_t;
    typedef logic [c_OFF_WIDTH-1:0] off_t;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } side_state_e;

    side_state_e            r_rd_state, r_wr_state;
    logic [ADDR_WIDTH-1:0]  r_rd_addr,  r_wr_addr;
    logic [LEN_WIDTH-1:0]   r_rd_rem,   r_wr_rem;
    logic [2:0]             r_wr_llen;
    logic                   r_done;

    logic        w_rd_act, w_wr_act;
    off_t        w_rd_off, w_wr_off;
    len_ext_t    w_rd_avail, w_rd_chunk;
    logic        w_rd_final, w_rd_hs;
    len_ext_t    w_wr_beats_llen, w_wr_beats, w_wr_beat_bytes, w_wr_bound;
    len_ext_t    w_wr_avail, w_wr_chunk;
    logic        w_wr_final, w_wr_hs;
    logic        w_accept, w_load, w_zero_accept;

    assign w_rd_act = (r_rd_state == ACTIVE);
    assign w_wr_act = (r_wr_state == ACTIVE);

    // Read side: never cross a data word
    assign w_rd_off   = r_rd_addr[c_OFF_WIDTH-1:0];
    assign w_rd_avail = len_ext_t'(c_STRB_WIDTH) - len_ext_t'(w_rd_off);
    assign w_rd_final = len_ext_t'(r_rd_rem) <= w_rd_avail;
    assign w_rd_chunk = w_rd_final ? len_ext_t'(r_rd_rem) : w_rd_avail;

    // Write side: burst boundary is the smallest of page, hard and runtime caps
    assign w_wr_beats_llen = len_ext_t'(1) << r_wr_llen;
    assign w_wr_beats      = (w_wr_beats_llen < len_ext_t'(MAX_BEATS)) ?
                             w_wr_beats_llen : len_ext_t'(MAX_BEATS);
    assign w_wr_beat_bytes = w_wr_beats << c_OFF_WIDTH;
    assign w_wr_bound      = (w_wr_beat_bytes < len_ext_t'(PAGE_SIZE)) ?
                             w_wr_beat_bytes : len_ext_t'(PAGE_SIZE);
    assign w_wr_avail      = w_wr_bound -
                             (len_ext_t'(r_wr_addr) & (w_wr_bound - len_ext_t'(1)));
    assign w_wr_final      = len_ext_t'(r_wr_rem) <= w_wr_avail;
    assign w_wr_chunk      = w_wr_final ? len_ext_t'(r_wr_rem) : w_wr_avail;
    assign w_wr_off        = r_wr_addr[c_OFF_WIDTH-1:0];

    assign r_valid_o = w_rd_act & ~flush_i;
    assign w_valid_o = w_wr_act & ~flush_i;
    assign w_rd_hs   = r_valid_o & r_ready_i;
    assign w_wr_hs   = w_valid_o & w_ready_i;

    // Data outputs are held at zero while a side is idle
    assign r_addr_o      = w_rd_act ? {r_rd_addr[ADDR_WIDTH-1:c_OFF_WIDTH], {c_OFF_WIDTH{1'b0}}} : '0;
    assign r_offset_o    = w_rd_act ? w_rd_off : '0;
    assign r_num_bytes_o = w_rd_act ? nbytes_t'(w_rd_chunk) : '0;
    assign w_addr_o      = w_wr_act ? {r_wr_addr[ADDR_WIDTH-1:c_OFF_WIDTH], {c_OFF_WIDTH{1'b0}}} : '0;
    assign w_offset_o    = w_wr_act ? w_wr_off : '0;
    assign w_len_o       = w_wr_act ?
                           8'((w_wr_chunk + len_ext_t'(w_wr_off) - len_ext_t'(1)) >> c_OFF_WIDTH) : '0;
    assign w_tailer_o    = w_wr_act ? off_t'(w_wr_chunk + len_ext_t'(w_wr_off)) : '0;
    assign w_last_o      = w_wr_act & w_wr_final;

    assign r_busy_o = w_rd_act;
    assign w_busy_o = w_wr_act;
    assign done_o   = r_done;

    // A new request may land on the same edge as both final handshakes
    assign req_ready_o = ~rst_i & ~flush_i & ~kill_i &
                         (~w_rd_act | (w_rd_hs & w_rd_final)) &
                         (~w_wr_act | (w_wr_hs & w_wr_final));
    assign w_accept    = req_valid_i & req_ready_o;

`ifdef IDMA_LEGALIZER_ZERO_LEN_EN
    assign w_load = (req_len_i != '0);
`else
    assign w_load = 1'b1;

    // Zero-length transfers are illegal in this build
    a_no_zero_len : assert property (@(posedge clk_i) disable iff (rst_i)
        (req_valid_i && req_ready_o) |-> (req_len_i != '0));
`endif

    assign w_zero_accept = w_accept & ~w_load;

    // Read-side state: load on accept, step by one word chunk per handshake
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rd_state <= IDLE;
            r_rd_addr  <= '0;
            r_rd_rem   <= '0;
        end else if (kill_i) begin
            r_rd_state <= IDLE;
        end else if (w_accept) begin
            r_rd_state <= w_load ? ACTIVE : IDLE;
            r_rd_addr  <= req_src_addr_i;
            r_rd_rem   <= req_len_i;
        end else if (w_rd_hs) begin
            if (w_rd_final) begin
                r_rd_state <= IDLE;
            end else begin
                r_rd_addr <= r_rd_addr + ADDR_WIDTH'(w_rd_chunk);
                r_rd_rem  <= r_rd_rem - LEN_WIDTH'(w_rd_chunk);
            end
        end
    end

    // Write-side state: load on accept, step by one burst per handshake
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_state <= IDLE;
            r_wr_addr  <= '0;
            r_wr_rem   <= '0;
            r_wr_llen  <= '0;
        end else if (kill_i) begin
            r_wr_state <= IDLE;
        end else if (w_accept) begin
            r_wr_state <= w_load ? ACTIVE : IDLE;
            r_wr_addr  <= req_dst_addr_i;
            r_wr_rem   <= req_len_i;
            r_wr_llen  <= req_max_llen_i;
        end else if (w_wr_hs) begin
            if (w_wr_final) begin
                r_wr_state <= IDLE;
            end else begin
                r_wr_addr <= r_wr_addr + ADDR_WIDTH'(w_wr_chunk);
                r_wr_rem  <= r_wr_rem - LEN_WIDTH'(w_wr_chunk);
            end
        end
    end

    // Done pulses the cycle after the last burst (or a zero-length accept)
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_done <= 1'b0;
        end else begin
            r_done <= ~kill_i & ((w_wr_hs & w_wr_final) | w_zero_accept);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_idma_legalizer_r_obi_w_axi_burst.sv
`default_nettype none
// ============================================================================
// Module      : tb_idma_legalizer_r_obi_w_axi_burst
// Description : Scoreboard bench for the OBI-read / AXI-write legalizer.
//               Expected read words and write bursts come from a byte-level
//               reference model; a monitor pops and compares on handshakes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_idma_legalizer_r_obi_w_axi_burst;

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  off;
        logic [2:0]  nb;
    } rd_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [1:0]  off;
        logic [1:0]  tail;
        logic        last;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_i, req_ready_o;
    logic [31:0] req_len_i, req_src_addr_i, req_dst_addr_i;
    logic [2:0]  req_max_llen_i;
    logic        r_valid_o, r_ready_i;
    logic [31:0] r_addr_o;
    logic [1:0]  r_offset_o;
    logic [2:0]  r_num_bytes_o;
    logic        w_valid_o, w_ready_i;
    logic [31:0] w_addr_o;
    logic [7:0]  w_len_o;
    logic [1:0]  w_offset_o, w_tailer_o;
    logic        w_last_o;
    logic        flush_i, kill_i, done_o, r_busy_o, w_busy_o;

    always #5 clk = ~clk;

    idma_legalizer_r_obi_w_axi_burst #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
        .LEN_WIDTH  (32),
        .MAX_BEATS  (256),
        .PAGE_SIZE  (4096)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_len_i      (req_len_i),
        .req_src_addr_i (req_src_addr_i),
        .req_dst_addr_i (req_dst_addr_i),
        .req_max_llen_i (req_max_llen_i),
        .r_valid_o      (r_valid_o),
        .r_ready_i      (r_ready_i),
        .r_addr_o       (r_addr_o),
        .r_offset_o     (r_offset_o),
        .r_num_bytes_o  (r_num_bytes_o),
        .w_valid_o      (w_valid_o),
        .w_ready_i      (w_ready_i),
        .w_addr_o       (w_addr_o),
        .w_len_o        (w_len_o),
        .w_offset_o     (w_offset_o),
        .w_tailer_o     (w_tailer_o),
        .w_last_o       (w_last_o),
        .flush_i        (flush_i),
        .kill_i         (kill_i),
        .done_o         (done_o),
        .r_busy_o       (r_busy_o),
        .w_busy_o       (w_busy_o)
    );

    int  checks = 0;
    int  errors = 0;
    rd_t qr[$];
    wr_t qw[$];
    bit  manual   = 1'b0;
    bit  r_hold   = 1'b0;
    bit  w_hold   = 1'b0;
    bit  flush_en = 1'b0;
    bit  exp_done = 1'b0;
    bit  mon_on   = 1'b0;

    function automatic void chk(input bit ok, input string name,
                                input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endfunction

    // Reference model: walk the byte range, cutting at word / burst boundaries
    function automatic void push_model(input bit [31:0] len, input bit [31:0] src,
                                       input bit [31:0] dst, input bit [2:0] llen);
        bit [31:0] a;
        longint    rem, n, b, beats, off;
        rd_t       r;
        wr_t       w;
        a = src;
        rem = len;
        while (rem > 0) begin
            off = longint'(a) % 4;
            n = 4 - off;
            if (n > rem) n = rem;
            r.addr = a & ~32'h3;
            r.off  = 2'(off);
            r.nb   = 3'(n);
            qr.push_back(r);
            a = a + 32'(n);
            rem = rem - n;
        end
        beats = 1 << llen;
        if (beats > 256) beats = 256;
        b = beats * 4;
        if (b > 4096) b = 4096;
        a = dst;
        rem = len;
        while (rem > 0) begin
            n = b - (longint'(a) % b);
            if (n > rem) n = rem;
            off = longint'(a) % 4;
            w.addr = a & ~32'h3;
            w.off  = 2'(off);
            w.len  = 8'((n + off - 1) / 4);
            w.tail = 2'((n + off) % 4);
            w.last = (rem == n);
            qw.push_back(w);
            a = a + 32'(n);
            rem = rem - n;
        end
    endfunction

    // Random ready / flush driver, parked while a test drives pins manually
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!manual) begin
                r_ready_i = !r_hold && ($urandom % 4 != 0);
                w_ready_i = !w_hold && ($urandom % 3 != 0);
                flush_i   = flush_en && ($urandom % 8 == 0);
            end
        end
    end

    // Monitor: compare every handshake and the done pulse against the model
    initial begin
        rd_t er;
        wr_t ew;
        bit  nd;
        wait (mon_on);
        forever begin
            @(negedge clk);
            chk(done_o == exp_done, "done", 64'(done_o), 64'(exp_done));
            if (flush_i && !kill_i)
                chk(!r_valid_o && !w_valid_o, "flush_valid", {r_valid_o, w_valid_o}, 0);
            nd = 1'b0;
            if (r_valid_o && r_ready_i && !kill_i) begin
                if (qr.size() == 0) chk(0, "r_unexpected", 64'(r_addr_o), 0);
                else begin
                    er = qr.pop_front();
                    chk({r_addr_o, r_offset_o, r_num_bytes_o} == er, "r_req",
                        64'({r_addr_o, r_offset_o, r_num_bytes_o}), 64'(er));
                end
            end
            if (w_valid_o && w_ready_i && !kill_i) begin
                if (qw.size() == 0) chk(0, "w_unexpected", 64'(w_addr_o), 0);
                else begin
                    ew = qw.pop_front();
                    nd = ew.last;
                    chk({w_addr_o, w_len_o, w_offset_o, w_tailer_o, w_last_o} == ew, "w_burst",
                        64'({w_addr_o, w_len_o, w_offset_o, w_tailer_o, w_last_o}), 64'(ew));
                end
            end
`ifdef IDMA_LEGALIZER_ZERO_LEN_EN
            if (req_valid_i && req_ready_o && req_len_i == 0 && !kill_i) nd = 1'b1;
`endif
            exp_done = nd;
        end
    end

    // Issue one request; called at posedge+1, returns at posedge+1 after accept
    task automatic send(input bit [31:0] len, input bit [31:0] src, input bit [31:0] dst,
                        input bit [2:0] llen, output int waited);
        bit ok = 1'b0;
        waited = 0;
        req_valid_i = 1'b1;
        req_len_i = len;
        req_src_addr_i = src;
        req_dst_addr_i = dst;
        req_max_llen_i = llen;
        while (waited < 3000) begin
            @(negedge clk);
            if (req_ready_o) begin
                ok = 1'b1;
                break;
            end
            waited++;
        end
        if (ok) begin
            push_model(len, src, dst, llen);
            @(posedge clk);
            #1;
        end else begin
            chk(0, "req_timeout", 64'(waited), 0);
        end
        req_valid_i = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (n < 6000 && (qr.size() != 0 || qw.size() != 0 || r_busy_o || w_busy_o)) begin
            @(negedge clk);
            n++;
        end
        chk(qr.size() == 0 && qw.size() == 0, "drain", 64'(qr.size() + qw.size()), 0);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        int w;
        rst = 1'b1;
        req_valid_i = 0; req_len_i = 0; req_src_addr_i = 0; req_dst_addr_i = 0;
        req_max_llen_i = 0; r_ready_i = 0; w_ready_i = 0; flush_i = 0; kill_i = 0;
        repeat (2) @(negedge clk);
        chk(req_ready_o == 0, "rst_req_ready", 64'(req_ready_o), 0);
        chk({r_valid_o, w_valid_o, done_o, r_busy_o, w_busy_o} == 0, "rst_ctrl",
            64'({r_valid_o, w_valid_o, done_o, r_busy_o, w_busy_o}), 0);
        chk({r_addr_o, w_addr_o, w_len_o, w_last_o} == 0, "rst_data",
            64'({r_addr_o, w_len_o, w_last_o}), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        mon_on = 1'b1;
        @(posedge clk);
        #1;

        // Directed cases from the datasheet examples
        send(10, 32'h1002, 32'h2001, 7, w);
        drain();
        send(32'h20, 32'h0, 32'h0FF0, 7, w);
        drain();
        send(40, 32'h0, 32'h0, 2, w);
        drain();

        // Write side stalled while reads drain
        @(negedge clk);
        w_hold = 1'b1;
        @(posedge clk);
        #1;
        send(10, 32'h1002, 32'h2001, 7, w);
        repeat (20) begin
            @(negedge clk);
            chk(req_ready_o == 0, "stall_ready", 64'(req_ready_o), 0);
        end
        chk(qr.size() == 0, "stall_reads_done", 64'(qr.size()), 0);
        chk(qw.size() == 1, "stall_writes_wait", 64'(qw.size()), 1);
        w_hold = 1'b0;
        drain();

        // Kill after the first of three bursts
        @(negedge clk);
        manual = 1'b1;
        @(posedge clk);
        #1;
        r_ready_i = 0; w_ready_i = 0; flush_i = 0;
        send(40, 32'h100, 32'h0, 2, w);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (w_valid_o) break;
        end
        @(posedge clk); #1; w_ready_i = 1'b1;
        @(posedge clk); #1; w_ready_i = 1'b0; kill_i = 1'b1;
        @(posedge clk); #1; kill_i = 1'b0;
        qr.delete();
        qw.delete();
        @(negedge clk);
        chk(!r_busy_o && !w_busy_o, "kill_busy", {r_busy_o, w_busy_o}, 0);
        chk(req_ready_o == 1, "kill_ready", 64'(req_ready_o), 1);
        manual = 1'b0;
        @(posedge clk);
        #1;
        send(12, 32'h3003, 32'h4002, 1, w);
        chk(w == 0, "accept_after_kill", 64'(w), 0);
        drain();

`ifdef IDMA_LEGALIZER_ZERO_LEN_EN
        send(0, 32'h10, 32'h20, 3, w);
        @(negedge clk);
        chk(!r_busy_o && !w_busy_o, "zero_busy", {r_busy_o, w_busy_o}, 0);
        drain();
`endif

        // Randomized back-to-back traffic with random flushes and address wrap
        @(negedge clk);
        flush_en = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 40; i++) begin
            bit [31:0] s, d;
            s = $urandom;
            d = $urandom;
            if ($urandom % 4 == 0) d = 32'hFFFF_FF00 | ($urandom % 256);
            if ($urandom % 4 == 0) s = 32'hFFFF_FFF0 | ($urandom % 16);
            send($urandom_range(1, 600), s, d, 3'($urandom % 8), w);
        end
        @(negedge clk);
        flush_en = 1'b0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
